regfile_param: RTL and testbench

- Parametrised multi-entry register file. Successor to the single 32-bit enabled register.
- Provides DEPTH entries of WIDTH bits, one write port and two independently enabled read ports.
- Read ports drive 0 when disabled, replacing tristate outputs.
- Adds an optional hardwired-zero entry 0 and a sequential scrub engine that clears every entry one per cycle on request.
- Sits in the processor datapath as the architectural register file.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_entry.sv | 29 ++
 rtl/regfile_param.sv | 148 ++++++++++++++
 tb/tb_regfile_param.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: scrub FSM states and default geometry.
// Optional same-cycle write-to-read forwarding in the top is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } scrub_state_t;

endpackage

// File: rtl/regfile_entry.sv
// Single storage word of the register file: enabled load, synchronous clear from the
// scrub engine, asynchronous active-low clear from the global reset.
module regfile_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_en,
    input  logic             i_sclr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Scrub clear has priority; the write port is blocked during a sweep anyway.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_q <= '0;
        end else if (i_sclr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_param.sv
// DEPTH x WIDTH register file, one write port, two enabled read ports, optional hardwired
// zero entry and a one-entry-per-cycle scrub engine. Define REGFILE_BYPASS_EN for forwarding.
import regfile_pkg::*;

module regfile_param #(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             w_en,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    output logic             w_ready,
    input  logic             r_enA,
    input  logic [AW-1:0]    r_addrA,
    output logic [WIDTH-1:0] r_dataA,
    input  logic             r_enB,
    input  logic [AW-1:0]    r_addrB,
    output logic [WIDTH-1:0] r_dataB,
    input  logic             scrub_req,
    output logic             scrub_busy,
    output logic             scrub_done
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("regfile_param: DEPTH must be at least 2");
    end

    scrub_state_t r_state;
    scrub_state_t w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;

    logic                        w_busy;
    logic                        w_wr_ok;
    logic                        w_wr_acc;
    logic [DEPTH-1:0][WIDTH-1:0] w_q;
    logic [WIDTH-1:0]            w_rdA;
    logic [WIDTH-1:0]            w_rdB;

    assign w_busy     = (r_state == ST_SWEEP);
    assign w_ready    = ~w_busy;
    assign scrub_busy = w_busy;
    assign scrub_done = (r_state == ST_DONE);

    // Address decode by explicit comparison so out-of-range addresses on a
    // non-power-of-two depth simply match nothing.
    function automatic logic addr_writable(input logic [AW-1:0] addr);
        logic v;
        v = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == AW'(i)) v = 1'b1;
        end
        if ((ZERO_REG != 0) && (addr == '0)) v = 1'b0;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] read_port(
        input logic                        en,
        input logic [AW-1:0]               addr,
        input logic [DEPTH-1:0][WIDTH-1:0] q
    );
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == AW'(i)) v = q[i];
        end
        if (!en || ((ZERO_REG != 0) && (addr == '0))) v = '0;
        return v;
    endfunction

    assign w_wr_ok  = addr_writable(w_addr);
    assign w_wr_acc = w_en & w_ready & w_wr_ok;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic w_we;
        logic w_sc;

        assign w_we = w_wr_acc && (w_addr == AW'(g));
        assign w_sc = w_busy && (r_ptr == AW'(g));

        regfile_entry #(
            .WIDTH (WIDTH)
        ) u_entry (
            .clk    (clk),
            .clr    (clr),
            .i_en   (w_we),
            .i_sclr (w_sc),
            .i_d    (w_data),
            .o_q    (w_q[g])
        );
    end

    assign w_rdA = read_port(r_enA, r_addrA, w_q);
    assign w_rdB = read_port(r_enB, r_addrB, w_q);

`ifdef REGFILE_BYPASS_EN
    // w_wr_acc already excludes busy cycles, invalid addresses and a hardwired entry 0.
    assign r_dataA = (r_enA && w_wr_acc && (r_addrA == w_addr)) ? w_data : w_rdA;
    assign r_dataB = (r_enB && w_wr_acc && (r_addrB == w_addr)) ? w_data : w_rdB;
`else
    assign r_dataA = w_rdA;
    assign r_dataB = w_rdB;
`endif

    // The end-of-sweep test uses DEPTH-1 directly so the pointer never wraps past the last entry.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (scrub_req) begin
                    w_state_nxt = ST_SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            ST_SWEEP: begin
                if (r_ptr == AW'(DEPTH - 1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: a 32-entry instance with a hardwired zero entry
// and a 20-entry instance without one, both checked against array models.
module tb_regfile_param;

    localparam int DA = 32;
    localparam int DB = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_clr, a_wen, a_wready, a_renA, a_renB, a_sreq, a_busy, a_done;
    logic [4:0]  a_waddr, a_raddrA, a_raddrB;
    logic [31:0] a_wdata, a_rdA, a_rdB;

    logic        b_clr, b_wen, b_wready, b_renA, b_renB, b_sreq, b_busy, b_done;
    logic [4:0]  b_waddr, b_raddrA, b_raddrB;
    logic [31:0] b_wdata, b_rdA, b_rdB;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ma [DA];
    logic [31:0] mb [DB];

    regfile_param #(.WIDTH(32), .DEPTH(DA), .ZERO_REG(1)) u_dut_a (
        .clk(clk), .clr(a_clr), .w_en(a_wen), .w_addr(a_waddr), .w_data(a_wdata),
        .w_ready(a_wready), .r_enA(a_renA), .r_addrA(a_raddrA), .r_dataA(a_rdA),
        .r_enB(a_renB), .r_addrB(a_raddrB), .r_dataB(a_rdB),
        .scrub_req(a_sreq), .scrub_busy(a_busy), .scrub_done(a_done)
    );

    regfile_param #(.WIDTH(32), .DEPTH(DB), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .clr(b_clr), .w_en(b_wen), .w_addr(b_waddr), .w_data(b_wdata),
        .w_ready(b_wready), .r_enA(b_renA), .r_addrA(b_raddrA), .r_dataA(b_rdA),
        .r_enB(b_renB), .r_addrB(b_raddrB), .r_dataB(b_rdB),
        .scrub_req(b_sreq), .scrub_busy(b_busy), .scrub_done(b_done)
    );

    function automatic logic [31:0] ref_a(input logic en, input int addr);
        if (!en || addr >= DA || addr == 0) return 32'h0;
        return ma[addr];
    endfunction

    function automatic logic [31:0] ref_b(input logic en, input int addr);
        if (!en || addr >= DB) return 32'h0;
        return mb[addr];
    endfunction

    // Expected read value when a write is being presented in the same cycle (idle file).
    function automatic logic [31:0] fwd_a(input logic en, input int ra, input logic we,
                                          input int wa, input logic [31:0] wd);
`ifdef REGFILE_BYPASS_EN
        if (en && we && wa < DA && wa != 0 && ra == wa) return wd;
`endif
        return ref_a(en, ra);
    endfunction

    function automatic logic [31:0] fwd_b(input logic en, input int ra, input logic we,
                                          input int wa, input logic [31:0] wd);
`ifdef REGFILE_BYPASS_EN
        if (en && we && wa < DB && ra == wa) return wd;
`endif
        return ref_b(en, ra);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input int addr, input logic [31:0] d);
        a_wen = 1'b1; a_waddr = addr[4:0]; a_wdata = d;
        tick();
        a_wen = 1'b0;
        if (addr < DA && addr != 0) ma[addr] = d;
    endtask

    task automatic wr_b(input int addr, input logic [31:0] d);
        b_wen = 1'b1; b_waddr = addr[4:0]; b_wdata = d;
        tick();
        b_wen = 1'b0;
        if (addr < DB) mb[addr] = d;
    endtask

    task automatic test_reset();
        int ra;
        for (int i = 0; i < DA; i++) ma[i] = 32'h0;
        for (int i = 0; i < DB; i++) mb[i] = 32'h0;
        a_clr = 1'b0; b_clr = 1'b0;
        a_wen = 1'b0; a_waddr = '0; a_wdata = '0; a_sreq = 1'b0;
        b_wen = 1'b0; b_waddr = '0; b_wdata = '0; b_sreq = 1'b0;
        a_renA = 1'b1; a_renB = 1'b1; b_renA = 1'b1; b_renB = 1'b1;
        a_raddrA = 5'd5; a_raddrB = 5'd31; b_raddrA = 5'd0; b_raddrB = 5'd19;
        tick(); tick();
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_a: got %b expected 0", a_busy); end
        n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL reset_done_a: got %b expected 0", a_done); end
        n_vec++; if (a_wready !== 1'b1) begin n_err++; $display("FAIL reset_ready_a: got %b expected 1", a_wready); end
        n_vec++; if (b_wready !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl_b: got ready=%b busy=%b done=%b expected 1 0 0", b_wready, b_busy, b_done);
        end
        a_clr = 1'b1; b_clr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ra = $urandom_range(0, 31);
            a_raddrA = ra[4:0]; b_raddrA = ra[4:0];
            tick();
            n_vec++; if (a_rdA !== ref_a(1'b1, ra)) begin n_err++; $display("FAIL reset_read_a[%0d]: got %h expected %h", ra, a_rdA, ref_a(1'b1, ra)); end
            n_vec++; if (b_rdA !== ref_b(1'b1, ra)) begin n_err++; $display("FAIL reset_read_b[%0d]: got %h expected %h", ra, b_rdA, ref_b(1'b1, ra)); end
        end
    endtask

    task automatic test_write_read();
        wr_a(5, 32'hDEAD_BEEF);
        a_renA = 1'b1; a_raddrA = 5'd5; a_renB = 1'b1; a_raddrB = 5'd5;
        #1;
        n_vec++; if (a_rdA !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_a5: got %h expected deadbeef", a_rdA); end
        n_vec++; if (a_rdB !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_b5: got %h expected deadbeef", a_rdB); end
        a_renB = 1'b0;
        #1;
        n_vec++; if (a_rdB !== 32'h0) begin n_err++; $display("FAIL rd_b_disabled: got %h expected 0", a_rdB); end
        a_renB = 1'b1;
        tick();
    endtask

    task automatic test_zero_reg();
        wr_a(0, 32'h1234_5678);
        a_renA = 1'b1; a_raddrA = 5'd0;
        #1;
        n_vec++; if (a_rdA !== 32'h0) begin n_err++; $display("FAIL zero_reg_a0: got %h expected 0", a_rdA); end
        wr_a(31, 32'h1234_5678);
        a_raddrA = 5'd31;
        #1;
        n_vec++; if (a_rdA !== 32'h1234_5678) begin n_err++; $display("FAIL entry31: got %h expected 12345678", a_rdA); end
        wr_b(0, 32'h0BAD_F00D);
        b_renA = 1'b1; b_raddrA = 5'd0;
        #1;
        n_vec++; if (b_rdA !== mb[0]) begin n_err++; $display("FAIL b_entry0: got %h expected %h", b_rdA, mb[0]); end
        tick();
    endtask

    task automatic test_bypass();
        logic [31:0] e;
        wr_a(7, 32'h1111_1111);
        a_wen = 1'b1; a_waddr = 5'd7; a_wdata = 32'hA5A5_A5A5;
        a_renA = 1'b1; a_raddrA = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        e = 32'hA5A5_A5A5;
`else
        e = 32'h1111_1111;
`endif
        n_vec++; if (a_rdA !== e) begin n_err++; $display("FAIL bypass_same_cycle: got %h expected %h", a_rdA, e); end
        tick();
        a_wen = 1'b0; ma[7] = 32'hA5A5_A5A5;
        n_vec++; if (a_rdA !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL bypass_next_cycle: got %h expected a5a5a5a5", a_rdA); end
        a_wen = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFF_0000; a_raddrA = 5'd0;
        #1;
        n_vec++; if (a_rdA !== 32'h0) begin n_err++; $display("FAIL bypass_zero_reg: got %h expected 0", a_rdA); end
        tick();
        a_wen = 1'b0;
    endtask

    task automatic test_random_rw();
        int wa, ra, rb;
        logic we, ea, eb;
        logic [31:0] wd;
        for (int k = 0; k < 60; k++) begin
            wa = $urandom_range(0, 31); ra = $urandom_range(0, 31); rb = $urandom_range(0, 31);
            if (k % 4 == 0) ra = wa;
            we = ($urandom_range(0, 3) != 0); ea = ($urandom_range(0, 4) != 0); eb = ($urandom_range(0, 4) != 0);
            wd = $urandom;
            a_wen = we; a_waddr = wa[4:0]; a_wdata = wd;
            a_renA = ea; a_raddrA = ra[4:0]; a_renB = eb; a_raddrB = rb[4:0];
            b_wen = we; b_waddr = wa[4:0]; b_wdata = ~wd;
            b_renA = ea; b_raddrA = ra[4:0]; b_renB = eb; b_raddrB = rb[4:0];
            #1;
            n_vec++; if (a_rdA !== fwd_a(ea, ra, we, wa, wd)) begin n_err++; $display("FAIL rand_a_portA[%0d]: got %h expected %h", ra, a_rdA, fwd_a(ea, ra, we, wa, wd)); end
            n_vec++; if (a_rdB !== fwd_a(eb, rb, we, wa, wd)) begin n_err++; $display("FAIL rand_a_portB[%0d]: got %h expected %h", rb, a_rdB, fwd_a(eb, rb, we, wa, wd)); end
            n_vec++; if (b_rdA !== fwd_b(ea, ra, we, wa, ~wd)) begin n_err++; $display("FAIL rand_b_portA[%0d]: got %h expected %h", ra, b_rdA, fwd_b(ea, ra, we, wa, ~wd)); end
            n_vec++; if (b_rdB !== fwd_b(eb, rb, we, wa, ~wd)) begin n_err++; $display("FAIL rand_b_portB[%0d]: got %h expected %h", rb, b_rdB, fwd_b(eb, rb, we, wa, ~wd)); end
            tick();
            a_wen = 1'b0; b_wen = 1'b0;
            if (we && wa < DA && wa != 0) ma[wa] = wd;
            if (we && wa < DB) mb[wa] = ~wd;
        end
    endtask

    task automatic test_scrub_a();
        int t, ra;
        logic [31:0] e;
        for (int i = 1; i < DA; i++) wr_a(i, $urandom | 32'h1);
        a_sreq = 1'b1; a_wen = 1'b1; a_waddr = 5'd3; a_wdata = 32'h3333_3333;
        #1;
        n_vec++; if (a_wready !== 1'b1) begin n_err++; $display("FAIL scrub_req_ready: got %b expected 1", a_wready); end
        tick();
        ma[3] = 32'h3333_3333; a_sreq = 1'b0; a_wen = 1'b0;
        t = 0;
        while (a_busy === 1'b1 && t < 100) begin
            ra = $urandom_range(0, 31);
            a_renA = 1'b1; a_raddrA = ra[4:0]; a_renB = 1'b1; a_raddrB = 5'd3;
            a_wen = (t >= 3); a_waddr = 5'd2; a_wdata = 32'hFFFF_FFFF; a_sreq = (t == 10);
            #1;
            n_vec++; if (a_wready !== 1'b0) begin n_err++; $display("FAIL sweep_ready[t=%0d]: got %b expected 0", t, a_wready); end
            e = (ra < t) ? 32'h0 : ref_a(1'b1, ra);
            n_vec++; if (a_rdA !== e) begin n_err++; $display("FAIL sweep_read[t=%0d,a=%0d]: got %h expected %h", t, ra, a_rdA, e); end
            e = (3 < t) ? 32'h0 : ma[3];
            n_vec++; if (a_rdB !== e) begin n_err++; $display("FAIL sweep_read3[t=%0d]: got %h expected %h", t, a_rdB, e); end
            tick();
            t++;
            a_wen = 1'b0; a_sreq = 1'b0;
        end
        n_vec++; if (t != DA) begin n_err++; $display("FAIL sweep_len_a: got %0d expected %0d", t, DA); end
        n_vec++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin n_err++; $display("FAIL done_pulse_a: got done=%b busy=%b expected 1 0", a_done, a_busy); end
        tick();
        n_vec++; if (a_done !== 1'b0 || a_busy !== 1'b0 || a_wready !== 1'b1) begin
            n_err++; $display("FAIL after_done_a: got done=%b busy=%b ready=%b expected 0 0 1", a_done, a_busy, a_wready);
        end
        for (int i = 0; i < DA; i++) ma[i] = 32'h0;
        for (int i = 0; i < DA; i++) begin
            a_raddrA = i[4:0]; a_raddrB = 5'(31 - i);
            #1;
            n_vec++; if (a_rdA !== 32'h0 || a_rdB !== 32'h0) begin n_err++; $display("FAIL scrubbed_a[%0d]: got %h/%h expected 0", i, a_rdA, a_rdB); end
            tick();
        end
    endtask

    task automatic test_scrub_b();
        int t;
        for (int i = 0; i < DB; i++) wr_b(i, $urandom | 32'h1);
        wr_b(25, 32'h5A5A_5A5A);
        b_renA = 1'b1; b_raddrA = 5'd25; b_renB = 1'b1; b_raddrB = 5'd19;
        #1;
        n_vec++; if (b_rdA !== 32'h0) begin n_err++; $display("FAIL oor_read_b: got %h expected 0", b_rdA); end
        n_vec++; if (b_rdB !== mb[19]) begin n_err++; $display("FAIL last_entry_b: got %h expected %h", b_rdB, mb[19]); end
        b_sreq = 1'b1;
        tick();
        b_sreq = 1'b0;
        t = 0;
        while (b_busy === 1'b1 && t < 100) begin
            tick();
            t++;
        end
        n_vec++; if (t != DB) begin n_err++; $display("FAIL sweep_len_b: got %0d expected %0d", t, DB); end
        n_vec++; if (b_done !== 1'b1) begin n_err++; $display("FAIL done_pulse_b: got %b expected 1", b_done); end
        tick();
        for (int i = 0; i < DB; i++) mb[i] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            b_raddrA = i[4:0];
            #1;
            n_vec++; if (b_rdA !== ref_b(1'b1, i)) begin n_err++; $display("FAIL scrubbed_b[%0d]: got %h expected %h", i, b_rdA, ref_b(1'b1, i)); end
            tick();
        end
    endtask

    task automatic test_reset_mid_sweep();
        int t;
        for (int k = 0; k < 6; k++) wr_a($urandom_range(1, 31), $urandom | 32'h1);
        a_sreq = 1'b1;
        tick();
        a_sreq = 1'b0;
        t = 0;
        while (a_busy === 1'b1 && t < 10) begin
            tick();
            t++;
        end
        n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL busy_before_abort: got %b expected 1", a_busy); end
        #2;
        a_clr = 1'b0;
        #1;
        n_vec++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin n_err++; $display("FAIL async_abort: got busy=%b done=%b expected 0 0", a_busy, a_done); end
        for (int i = 0; i < DA; i++) ma[i] = 32'h0;
        tick(); tick();
        a_clr = 1'b1;
        for (int i = 0; i < DA; i++) begin
            a_renA = 1'b1; a_raddrA = i[4:0];
            #1;
            n_vec++; if (a_done !== 1'b0 || a_wready !== 1'b1) begin n_err++; $display("FAIL post_abort_ctrl[%0d]: got done=%b ready=%b expected 0 1", i, a_done, a_wready); end
            n_vec++; if (a_rdA !== ref_a(1'b1, i)) begin n_err++; $display("FAIL post_abort_read[%0d]: got %h expected %h", i, a_rdA, ref_a(1'b1, i)); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_random_rw();
        test_scrub_a();
        test_scrub_b();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
